// File: rtl/perif_pkg.sv
// Shared definitions for the peripheral-region UART transmitter:
// register offsets, STATUS bit positions and the TX state encoding.
package perif_pkg;

    localparam logic [7:0] PERIF_TXDATA = 8'h00;
    localparam logic [7:0] PERIF_STATUS = 8'h08;
    localparam logic [7:0] PERIF_DIV    = 8'h10;

    localparam int STATUS_FULL      = 0;
    localparam int STATUS_EMPTY     = 1;
    localparam int STATUS_BUSY      = 2;
    localparam int STATUS_OVERFLOW  = 3;
    localparam int STATUS_COUNT_LSB = 4;
    localparam int STATUS_IRQ_EN    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/perif_uart_tx_if.sv
// Memory-bus slice seen by the UART peripheral: select, write strobe,
// byte offset, write data and combinational read data.
interface perif_uart_tx_if;
    logic        cs;
    logic        write_en;
    logic [7:0]  address;
    logic [63:0] data_in;
    logic [63:0] data_out;

    modport master (output cs, output write_en, output address, output data_in, input data_out);
    modport slave  (input cs, input write_en, input address, input data_in, output data_out);
endinterface

// File: rtl/perif_fifo.sv
// Synchronous circular-buffer FIFO with explicit occupancy count.
// A push into a full FIFO only lands when a pop happens in the same cycle.
module perif_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/perif_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIV registers, TX FIFO
// and serialiser. Optional PERIF_UART_IRQ_EN adds an irq output and STATUS[8] enable.
module perif_uart_tx
    import perif_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 15,
    parameter int DIV_W       = 16
) (
    input  logic            clock,
    input  logic            reset,
    perif_uart_tx_if.slave  bus,
`ifdef PERIF_UART_IRQ_EN
    output logic            irq,
`endif
    output logic            tx
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e        state_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] active_div_r;
    logic [DIV_W-1:0] baud_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             tx_r;
    logic             overflow_r;
    logic             irq_en_s;

    logic             wr_s;
    logic             wr_txdata_s;
    logic             wr_status_s;
    logic             wr_div_s;
    logic             pop_s;
    logic             busy_s;
    logic             bit_done_s;
    logic [7:0]       fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [15:0]      status_s;
    logic [63:0]      rd_data_s;
    logic             unused_data_s;

    assign wr_s        = bus.cs & bus.write_en;
    assign wr_txdata_s = wr_s & (bus.address == PERIF_TXDATA);
    assign wr_status_s = wr_s & (bus.address == PERIF_STATUS);
    assign wr_div_s    = wr_s & (bus.address == PERIF_DIV);
    assign busy_s      = (state_r != IDLE);
    assign pop_s       = (state_r == IDLE) & ~fifo_empty_s;
    assign bit_done_s  = (baud_cnt_r == active_div_r);
    assign tx          = tx_r;
    assign unused_data_s = ^bus.data_in[63:DIV_W];

    perif_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (wr_txdata_s),
        .pop     (pop_s),
        .wr_data (bus.data_in[7:0]),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Divisor and sticky overflow; a drop only happens when no pop frees a slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_r      <= DIV_W'(DEFAULT_DIV);
            overflow_r <= 1'b0;
        end else begin
            if (wr_txdata_s && fifo_full_s && !pop_s) overflow_r <= 1'b1;
            else if (wr_status_s)                     overflow_r <= 1'b0;
            if (wr_div_s) div_r <= bus.data_in[DIV_W-1:0];
        end
    end

`ifdef PERIF_UART_IRQ_EN
    logic irq_en_r;
    logic irq_r;
    assign irq_en_s = irq_en_r;
    assign irq      = irq_r;

    // Interrupt enable and registered "drained" interrupt.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (wr_status_s) irq_en_r <= bus.data_in[STATUS_IRQ_EN];
            irq_r <= irq_en_r & fifo_empty_s & ~busy_s;
        end
    end
`else
    assign irq_en_s = 1'b0;
`endif

    // Serialiser: divisor is latched at pop so mid-frame DIV writes wait a frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            tx_r         <= 1'b1;
            baud_cnt_r   <= {DIV_W{1'b0}};
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'd0;
            active_div_r <= DIV_W'(DEFAULT_DIV);
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (pop_s) begin
                        shift_r      <= fifo_head_s;
                        active_div_r <= div_r;
                        baud_cnt_r   <= {DIV_W{1'b0}};
                        bit_cnt_r    <= 3'd0;
                        tx_r         <= 1'b0;
                        state_r      <= START;
                    end
                end
                START: begin
                    if (bit_done_s) begin
                        baud_cnt_r <= {DIV_W{1'b0}};
                        tx_r       <= shift_r[0];
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
                DATA: begin
                    if (bit_done_s) begin
                        baud_cnt_r <= {DIV_W{1'b0}};
                        if (bit_cnt_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
                STOP: begin
                    tx_r <= 1'b1;
                    if (bit_done_s) begin
                        baud_cnt_r <= {DIV_W{1'b0}};
                        state_r    <= IDLE;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_s                     = 16'd0;
        status_s[STATUS_FULL]        = fifo_full_s;
        status_s[STATUS_EMPTY]       = fifo_empty_s;
        status_s[STATUS_BUSY]        = busy_s;
        status_s[STATUS_OVERFLOW]    = overflow_r;
        status_s[STATUS_COUNT_LSB+:4] = 4'(fifo_count_s);
        status_s[STATUS_IRQ_EN]      = irq_en_s;
    end

    // Combinational read mux; zero whenever the peripheral is not being read.
    always_comb begin
        rd_data_s = 64'd0;
        if (bus.cs && !bus.write_en) begin
            case (bus.address)
                PERIF_STATUS: rd_data_s = {48'd0, status_s};
                PERIF_DIV:    rd_data_s = 64'(div_r);
                default:      rd_data_s = 64'd0;
            endcase
        end else begin
            rd_data_s = 64'd0;
        end
    end

    assign bus.data_out = rd_data_s;

endmodule

// File: tb/tb_perif_uart_tx.sv
// Self-checking bench for perif_uart_tx: bus tasks drive registers, a
// serial monitor checks every frame against a scoreboard of queued bytes.
module tb_perif_uart_tx;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         gap;
    } exp_t;

    logic clock;
    logic reset;
    logic tx;
`ifdef PERIF_UART_IRQ_EN
    logic irq;
`endif

    perif_uart_tx_if bus_if ();

    perif_uart_tx #(.FIFO_DEPTH(4), .DEFAULT_DIV(15), .DIV_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if),
`ifdef PERIF_UART_IRQ_EN
        .irq   (irq),
`endif
        .tx    (tx)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    bit   mon_en   = 1'b1;
    bit   mon_busy = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic bus_write(input logic [7:0] addr, input logic [63:0] data);
        @(negedge clock);
        bus_if.cs = 1'b1; bus_if.write_en = 1'b1;
        bus_if.address = addr; bus_if.data_in = data;
        @(posedge clock);
        #1;
        bus_if.cs = 1'b0; bus_if.write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [63:0] data);
        @(negedge clock);
        bus_if.cs = 1'b1; bus_if.write_en = 1'b0; bus_if.address = addr;
        #1;
        data = bus_if.data_out;
        bus_if.cs = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && !mon_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Serial receiver: checks each cycle of every bit, the byte, and start-to-start spacing.
    initial begin : monitor
        exp_t       e;
        logic [7:0] got;
        bit         timing_ok;
        logic       exp_bit;
        int         start_cyc;
        int         last_start;
        last_start = 0;
        forever begin
            @(negedge clock);
            if (mon_en && tx === 1'b0) begin
                mon_busy  = 1'b1;
                start_cyc = cyc;
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d with nothing queued", cyc);
                    for (int i = 0; i < 2000 && tx !== 1'b1; i++) @(negedge clock);
                end else begin
                    e = sb.pop_front();
                    got = 8'h00;
                    timing_ok = 1'b1;
                    for (int b = 0; b < 10; b++) begin
                        exp_bit = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : e.data[b-1]);
                        for (int c = 0; c <= e.div; c++) begin
                            if (b != 0 || c != 0) @(negedge clock);
                            if (tx !== exp_bit) timing_ok = 1'b0;
                            if (c == 0 && b >= 1 && b <= 8) got[b-1] = tx;
                        end
                    end
                    n_checks++;
                    if (got !== e.data) begin
                        n_fail++;
                        $display("FAIL frame_data: got 0x%02h expected 0x%02h", got, e.data);
                    end
                    n_checks++;
                    if (!timing_ok) begin
                        n_fail++;
                        $display("FAIL frame_timing: byte 0x%02h bit levels/widths wrong for div %0d", e.data, e.div);
                    end
                    if (e.gap != 0) begin
                        n_checks++;
                        if (start_cyc - last_start != e.gap) begin
                            n_fail++;
                            $display("FAIL frame_gap: byte 0x%02h start spacing %0d expected %0d",
                                     e.data, start_cyc - last_start, e.gap);
                        end
                    end
                end
                last_start = start_cyc;
                mon_busy = 1'b0;
            end
        end
    end

    task automatic test_reset();
        logic [63:0] rd;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        bus_read(8'h08, rd);
        n_checks++;
        if (rd !== 64'h2) begin n_fail++; $display("FAIL reset_status: got 0x%0h expected 0x2", rd); end
        bus_read(8'h10, rd);
        n_checks++;
        if (rd !== 64'd15) begin n_fail++; $display("FAIL reset_div: got %0d expected 15", rd); end
        bus_read(8'h00, rd);
        n_checks++;
        if (rd !== 64'd0) begin n_fail++; $display("FAIL read_txdata: got 0x%0h expected 0", rd); end
        bus_read(8'h18, rd);
        n_checks++;
        if (rd !== 64'd0) begin n_fail++; $display("FAIL read_unmapped: got 0x%0h expected 0", rd); end
        @(negedge clock);
        bus_if.address = 8'h10;
        #1;
        n_checks++;
        if (bus_if.data_out !== 64'd0) begin
            n_fail++; $display("FAIL unselected_read: got 0x%0h expected 0", bus_if.data_out);
        end
    endtask

    task automatic test_basic_frame();
        logic [63:0] rd;
        int          busy_cnt;
        bit          seen;
        bit          ok;
        bus_write(8'h10, 64'hFFFF_FFFF_0000_0003);
        bus_read(8'h10, rd);
        n_checks++;
        if (rd !== 64'd3) begin n_fail++; $display("FAIL div_write: got 0x%0h expected 3", rd); end
        sb.push_back('{data: 8'h55, div: 3, gap: 0});
        bus_write(8'h00, 64'h55);
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus_read(8'h08, rd);
            if (rd[2]) begin busy_cnt++; seen = 1'b1; end
            else if (seen) break;
        end
        n_checks++;
        if (busy_cnt != 40) begin n_fail++; $display("FAIL busy_length: got %0d expected 40", busy_cnt); end
        wait_drain(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_drain: timeout, %0d frames outstanding", sb.size()); end
        bus_read(8'h08, rd);
        n_checks++;
        if (rd !== 64'h2) begin n_fail++; $display("FAIL basic_status_after: got 0x%0h expected 0x2", rd); end
    endtask

    task automatic test_overflow();
        logic [63:0] rd;
        logic [7:0]  bytes [5];
        bit          ok;
        bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        bus_write(8'h10, 64'd0);
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{data: bytes[i], div: 0, gap: (i == 0) ? 0 : 11});
            bus_write(8'h00, {56'd0, bytes[i]});
        end
        bus_write(8'h00, 64'hF6);
        bus_write(8'h00, 64'h07);
        bus_read(8'h08, rd);
        n_checks++;
        if (rd !== 64'h4D) begin n_fail++; $display("FAIL overflow_status: got 0x%0h expected 0x4d", rd); end
        bus_write(8'h08, 64'd0);
        bus_read(8'h08, rd);
        n_checks++;
        if (rd[3] !== 1'b0 || rd[7:4] !== 4'd4) begin
            n_fail++; $display("FAIL overflow_clear: got 0x%0h expected ovf=0 count=4", rd);
        end
        wait_drain(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL overflow_drain: timeout, %0d frames outstanding", sb.size()); end
    endtask

    task automatic test_div_change();
        logic [63:0] rd;
        bit          ok;
        bus_write(8'h10, 64'd3);
        sb.push_back('{data: 8'h3C, div: 3, gap: 0});
        sb.push_back('{data: 8'hC5, div: 7, gap: 41});
        bus_write(8'h00, 64'h3C);
        bus_write(8'h00, 64'hC5);
        repeat (10) @(negedge clock);
        bus_write(8'h10, 64'd7);
        bus_read(8'h10, rd);
        n_checks++;
        if (rd !== 64'd7) begin n_fail++; $display("FAIL div_midframe_read: got %0d expected 7", rd); end
        wait_drain(300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL div_change_drain: timeout, %0d frames outstanding", sb.size()); end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] rd;
        logic        prev;
        int          edges;
        mon_en = 1'b0;
        bus_write(8'h10, 64'd3);
        bus_write(8'h00, 64'h0F);
        bus_write(8'h00, 64'h33);
        repeat (12) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL midframe_reset_tx: got %b expected 1", tx); end
        @(negedge clock);
        reset = 1'b0;
        bus_read(8'h08, rd);
        n_checks++;
        if (rd !== 64'h2) begin n_fail++; $display("FAIL midframe_reset_status: got 0x%0h expected 0x2", rd); end
        bus_read(8'h10, rd);
        n_checks++;
        if (rd !== 64'd15) begin n_fail++; $display("FAIL midframe_reset_div: got %0d expected 15", rd); end
        edges = 0;
        prev = tx;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (tx !== prev) edges++;
            prev = tx;
        end
        n_checks++;
        if (edges != 0 || tx !== 1'b1) begin
            n_fail++; $display("FAIL midframe_reset_quiet: got %0d tx transitions, tx=%b, expected 0 and 1", edges, tx);
        end
        mon_en = 1'b1;
    endtask

`ifdef PERIF_UART_IRQ_EN
    task automatic test_irq();
        logic [63:0] rd;
        bit          seen;
        bit          irq_bad;
        bit          ok;
        bus_write(8'h10, 64'd1);
        bus_write(8'h08, 64'h100);
        @(posedge clock);
        #1;
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_enable: got %b expected 1", irq); end
        sb.push_back('{data: 8'h96, div: 1, gap: 0});
        bus_write(8'h00, 64'h96);
        seen = 1'b0;
        irq_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus_read(8'h08, rd);
            if (rd[2]) begin
                seen = 1'b1;
                if (irq !== 1'b0) irq_bad = 1'b1;
            end else if (seen) break;
        end
        n_checks++;
        if (!seen || irq_bad) begin n_fail++; $display("FAIL irq_busy: seen_busy=%b irq_high_while_busy=%b expected 1 and 0", seen, irq_bad); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag: got %b expected 0 on first idle cycle", irq); end
        @(negedge clock);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b expected 1", irq); end
        bus_write(8'h08, 64'd0);
        @(posedge clock);
        #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disable: got %b expected 0", irq); end
        wait_drain(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL irq_drain: timeout, %0d frames outstanding", sb.size()); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus_if.cs = 1'b0;
        bus_if.write_en = 1'b0;
        bus_if.address = 8'h00;
        bus_if.data_in = 64'd0;
        test_reset();
        test_basic_frame();
        test_overflow();
        test_div_change();
        test_reset_midframe();
`ifdef PERIF_UART_IRQ_EN
        test_irq();
`endif
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: %0d frames never seen", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
